saph_pixel_unpack: RTL and testbench

Converts a stream of 32-bit framebuffer/texture memory words into a stream of `saph_types::color` ARGB8888 pixels, using a runtime `pixfmt` descriptor. It sits directly downstream of the memory read path and upstream of the blend/raster consumers, which only handle `color`. Each accepted word yields one or more pixels: pixels are packed LSB-first, and any remainder bits too small for a whole pixel are discarded.

---
 rtl/saph_types.sv | 40 ++++
 rtl/saph_chan_expand.sv | 24 ++
 rtl/saph_pixel_unpack.sv | 194 +++++++++++++++++++
 tb/tb_saph_pixel_unpack.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saph_types.sv
// Shared pixel, colour and format-descriptor types for the saph render path.
package saph_types;

    localparam int unsigned SAPH_WORD_W = 32;
    localparam int unsigned SAPH_OFS_W  = 6;

    localparam logic [3:0]  SAPH_PIXTYPE_RGB  = 4'd0;
    localparam logic [3:0]  SAPH_PIXTYPE_ARGB = 4'd1;
    localparam logic [3:0]  SAPH_PIXTYPE_GREY = 4'd2;
    localparam logic [31:0] SAPH_ERROR_COLOR  = 32'hFFFF00FF;

    typedef struct packed {
        logic [4:0] pos;
        logic [2:0] width;
    } chfmt;

    typedef struct packed {
        logic [3:0] pixtype;
        logic [4:0] size;
        chfmt       a;
        chfmt       r;
        chfmt       g;
        chfmt       b;
    } pixfmt;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color;

    // Mask keeping the low p bits of a word, p in 1..32.
    function automatic logic [SAPH_WORD_W-1:0] saph_low_mask(input logic [SAPH_OFS_W-1:0] p);
        logic [SAPH_WORD_W:0] m;
        m = ((SAPH_WORD_W+1)'(1) << p) - (SAPH_WORD_W+1)'(1);
        return m[SAPH_WORD_W-1:0];
    endfunction

endpackage

// File: rtl/saph_chan_expand.sv
// Extracts one channel field from a pixel and widens it to 8 bits by MSB-first replication.
module saph_chan_expand
    import saph_types::*;
(
    input  logic [SAPH_WORD_W-1:0] i_pixel,
    input  chfmt                   i_chfmt,
    output logic [7:0]             o_chan_c
);

    logic [7:0] w_field;
    logic [2:0] w_idx;

    // Positions past bit 31 shift in zeros; replication cycles through the field MSB-first.
    always_comb begin
        w_field  = 8'(i_pixel >> i_chfmt.pos);
        o_chan_c = '0;
        w_idx    = i_chfmt.width;
        for (int i = 7; i >= 0; i--) begin
            o_chan_c[i] = w_field[w_idx];
            w_idx       = (w_idx == 3'd0) ? i_chfmt.width : w_idx - 3'd1;
        end
    end

endmodule

// File: rtl/saph_pixel_unpack.sv
// Unpacks 32-bit memory words into ARGB8888 pixels using a runtime pixfmt descriptor.
// Build option SAPH_PIXEL_UNPACK_OUTREG_EN adds a flop-driven skid output stage (latency 3).
module saph_pixel_unpack
    import saph_types::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  pixfmt                  fmt,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SAPH_WORD_W-1:0] in_word,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output color                   out_color,
    output logic                   out_last
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]             r_state, w_state_nxt;
    logic [SAPH_WORD_W-1:0] r_word,  w_word_nxt;
    pixfmt                  r_fmt,   w_fmt_nxt;
    logic                   r_last,  w_last_nxt;
    logic [SAPH_OFS_W-1:0]  r_ofs,   w_ofs_nxt;

    logic [SAPH_OFS_W-1:0]  w_psize;
    logic [SAPH_OFS_W:0]    w_end2;
    logic                   w_final;
    logic                   w_adv;
    logic                   w_in_xfer;
    logic                   w_dn_ready;
    logic                   w_load_ok;
    logic [SAPH_WORD_W-1:0] w_pixel;
    logic [7:0]             w_ch_a, w_ch_r, w_ch_g, w_ch_b;
    color                   w_color;

    logic                   r_p_valid;
    color                   r_p_color;
    logic                   r_p_last;

    // Word finishes when another whole pixel would not fit after the current one.
    always_comb begin
        w_psize   = SAPH_OFS_W'(r_fmt.size) + SAPH_OFS_W'(1);
        w_end2    = (SAPH_OFS_W+1)'(r_ofs) + (SAPH_OFS_W+1)'(w_psize) + (SAPH_OFS_W+1)'(w_psize);
        w_final   = w_end2 > (SAPH_OFS_W+1)'(SAPH_WORD_W);
        w_load_ok = !r_p_valid || w_dn_ready;
        w_adv     = (r_state == ST_HOLD) && w_load_ok;
        in_ready  = !rst && !clear && ((r_state == ST_EMPTY) || (w_adv && w_final));
        w_in_xfer = in_valid && in_ready;
        w_pixel   = (r_word >> r_ofs) & saph_low_mask(w_psize);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_word  <= '0;
            r_fmt   <= '0;
            r_last  <= 1'b0;
            r_ofs   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_fmt   <= w_fmt_nxt;
            r_last  <= w_last_nxt;
            r_ofs   <= w_ofs_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_fmt_nxt   = r_fmt;
        w_last_nxt  = r_last;
        w_ofs_nxt   = r_ofs;
        if (clear) begin
            w_state_nxt = ST_EMPTY;
            w_ofs_nxt   = '0;
        end else if (w_in_xfer) begin
            w_state_nxt = ST_HOLD;
            w_word_nxt  = in_word;
            w_fmt_nxt   = fmt;
            w_last_nxt  = in_last;
            w_ofs_nxt   = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_adv) begin
                        if (w_final) begin
                            w_state_nxt = ST_EMPTY;
                            w_ofs_nxt   = '0;
                        end else begin
                            w_ofs_nxt = r_ofs + w_psize;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    saph_chan_expand u_exp_a (.i_pixel(w_pixel), .i_chfmt(r_fmt.a), .o_chan_c(w_ch_a));
    saph_chan_expand u_exp_r (.i_pixel(w_pixel), .i_chfmt(r_fmt.r), .o_chan_c(w_ch_r));
    saph_chan_expand u_exp_g (.i_pixel(w_pixel), .i_chfmt(r_fmt.g), .o_chan_c(w_ch_g));
    saph_chan_expand u_exp_b (.i_pixel(w_pixel), .i_chfmt(r_fmt.b), .o_chan_c(w_ch_b));

    // Unknown categories render as error magenta so bad descriptors are visible on screen.
    always_comb begin
        w_color = SAPH_ERROR_COLOR;
        case (r_fmt.pixtype)
            SAPH_PIXTYPE_RGB:  w_color = {8'hFF, w_ch_r, w_ch_g, w_ch_b};
            SAPH_PIXTYPE_ARGB: w_color = {w_ch_a, w_ch_r, w_ch_g, w_ch_b};
            SAPH_PIXTYPE_GREY: w_color = {8'hFF, w_ch_r, w_ch_r, w_ch_r};
            default:           w_color = SAPH_ERROR_COLOR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_valid <= 1'b0;
            r_p_color <= '0;
            r_p_last  <= 1'b0;
        end else if (clear) begin
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
        end else if (w_load_ok) begin
            r_p_valid <= w_adv;
            if (w_adv) begin
                r_p_color <= w_color;
                r_p_last  <= r_last && w_final;
            end
        end
    end

`ifdef SAPH_PIXEL_UNPACK_OUTREG_EN
    logic r_o_valid;
    color r_o_color;
    logic r_o_last;
    logic r_sk_valid;
    color r_sk_color;
    logic r_sk_last;
    logic w_o_free;

    assign w_dn_ready = !r_sk_valid;
    assign w_o_free   = !r_o_valid || out_ready;

    // Skid slot catches the one pixel in flight when the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_valid  <= 1'b0;
            r_o_color  <= '0;
            r_o_last   <= 1'b0;
            r_sk_valid <= 1'b0;
            r_sk_color <= '0;
            r_sk_last  <= 1'b0;
        end else if (clear) begin
            r_o_valid  <= 1'b0;
            r_o_last   <= 1'b0;
            r_sk_valid <= 1'b0;
        end else if (w_o_free) begin
            if (r_sk_valid) begin
                r_o_valid  <= 1'b1;
                r_o_color  <= r_sk_color;
                r_o_last   <= r_sk_last;
                r_sk_valid <= 1'b0;
            end else begin
                r_o_valid <= r_p_valid;
                if (r_p_valid) begin
                    r_o_color <= r_p_color;
                    r_o_last  <= r_p_last;
                end
            end
        end else if (r_p_valid && !r_sk_valid) begin
            r_sk_valid <= 1'b1;
            r_sk_color <= r_p_color;
            r_sk_last  <= r_p_last;
        end
    end

    assign out_valid = r_o_valid;
    assign out_color = r_o_color;
    assign out_last  = r_o_last;
`else
    assign w_dn_ready = out_ready;
    assign out_valid  = r_p_valid;
    assign out_color  = r_p_color;
    assign out_last   = r_p_last;
`endif

endmodule

// File: tb/tb_saph_pixel_unpack.sv
// Self-checking bench for saph_pixel_unpack: vector table plus scoreboard and corner-case sequences.
module tb_saph_pixel_unpack;
    import saph_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    pixfmt       fmt;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    color        out_color;
    logic        out_last;

    saph_pixel_unpack dut (
        .clk(clk), .rst(rst), .clear(clear), .fmt(fmt),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_color(out_color), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        pixfmt       fmt;
        logic [31:0] word;
        logic        last;
        int          n;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] rest;
    } vec_t;

    typedef struct packed {
        logic [31:0] c;
        logic        l;
    } exp_t;

    localparam int NV = 9;
    vec_t  tbl[NV];
    exp_t  q[$];
    exp_t  e;
    int    nvec = 0;
    int    nerr = 0;
    logic  rand_rdy = 1'b0;

    function automatic pixfmt mkfmt(input logic [3:0] t, input logic [4:0] sz,
                                    input logic [4:0] ap, input logic [2:0] aw,
                                    input logic [4:0] rp, input logic [2:0] rw,
                                    input logic [4:0] gp, input logic [2:0] gw,
                                    input logic [4:0] bp, input logic [2:0] bw);
        pixfmt f;
        f.pixtype = t;  f.size = sz;
        f.a.pos = ap;   f.a.width = aw;
        f.r.pos = rp;   f.r.width = rw;
        f.g.pos = gp;   f.g.width = gw;
        f.b.pos = bp;   f.b.width = bw;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic push_exp(input vec_t v);
        logic [31:0] c;
        for (int k = 0; k < v.n; k++) begin
            c = (k == 0) ? v.e0 : (k == 1) ? v.e1 : (k == 2) ? v.e2 : v.rest;
            q.push_back('{c: c, l: (v.last && (k == v.n - 1))});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the word is taken.
    task automatic send(input pixfmt f, input logic [31:0] w, input logic l);
        logic ok;
        fmt = f; in_word = w; in_last = l; in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        push_exp(v);
        send(v.fmt, v.word, v.last);
    endtask

    task automatic wait_drain;
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid;
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_out_valid", 32'(ok), 32'd1);
    endtask

    // Scoreboard: every accepted pixel must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            nvec++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL pixel_unexpected: got %h last %b, queue empty", out_color, out_last);
            end else begin
                e = q.pop_front();
                if (out_color !== e.c || out_last !== e.l) begin
                    nerr++;
                    $display("FAIL pixel: got %h last %b expected %h last %b",
                             out_color, out_last, e.c, e.l);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bw[4];
        logic [7:0]  vpat;
        logic [31:0] held;
        pixfmt       argb;

        tbl[0] = '{mkfmt(SAPH_PIXTYPE_RGB, 15, 0, 0, 11, 4, 5, 5, 0, 4), 32'hF80007E0, 1'b1, 2,
                   32'hFF00FF00, 32'hFFFF0000, 32'h0, 32'h0};
        tbl[1] = '{mkfmt(SAPH_PIXTYPE_ARGB, 31, 24, 7, 16, 7, 8, 7, 0, 7), 32'h80123456, 1'b0, 1,
                   32'h80123456, 32'h0, 32'h0, 32'h0};
        tbl[2] = '{mkfmt(SAPH_PIXTYPE_GREY, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h00000005, 1'b1, 32,
                   32'hFFFFFFFF, 32'hFF000000, 32'hFFFFFFFF, 32'hFF000000};
        tbl[3] = '{mkfmt(SAPH_PIXTYPE_RGB, 23, 0, 0, 16, 7, 8, 7, 0, 7), 32'hAB112233, 1'b0, 1,
                   32'hFF112233, 32'h0, 32'h0, 32'h0};
        tbl[4] = '{mkfmt(SAPH_PIXTYPE_RGB, 7, 0, 0, 5, 2, 2, 2, 0, 1), 32'h0300FFB4, 1'b1, 4,
                   32'hFFB6B600, 32'hFFFFFFFF, 32'hFF000000, 32'hFF0000FF};
        tbl[5] = '{mkfmt(SAPH_PIXTYPE_ARGB, 15, 12, 3, 8, 3, 4, 3, 0, 3), 32'h12345678, 1'b1, 2,
                   32'h55667788, 32'h11223344, 32'h0, 32'h0};
        tbl[6] = '{mkfmt(SAPH_PIXTYPE_GREY, 9, 0, 0, 2, 7, 0, 0, 0, 0), 32'hC00293FC, 1'b1, 3,
                   32'hFFFFFFFF, 32'hFF292929, 32'hFF000000, 32'h0};
        tbl[7] = '{mkfmt(SAPH_PIXTYPE_RGB, 31, 0, 0, 28, 7, 0, 7, 8, 7), 32'hF0000102, 1'b0, 1,
                   32'hFF0F0201, 32'h0, 32'h0, 32'h0};
        tbl[8] = '{mkfmt(4'd5, 7, 0, 0, 0, 0, 0, 0, 0, 0), 32'h12345678, 1'b1, 4,
                   32'hFFFF00FF, 32'hFFFF00FF, 32'hFFFF00FF, 32'hFFFF00FF};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_word = '0; in_last = 1'b0;
        fmt = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_color", out_color, 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) run_vec(tbl[i]);
        wait_drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < NV; i++) run_vec(tbl[i]);
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_drain();

        // Back-to-back ARGB8888 words: one pixel per cycle, no bubbles.
        argb = tbl[1].fmt;
        bw[0] = 32'h11223344; bw[1] = 32'hDEADBEEF; bw[2] = 32'h00000000; bw[3] = 32'hCAFEF00D;
        for (int c = 0; c < 4; c++) q.push_back('{c: bw[c], l: (c == 3)});
        vpat = '0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                fmt = argb; in_word = bw[c]; in_last = (c == 3); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            vpat[c] = out_valid;
            if (c < 4) chk("b2b_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        chk("b2b_valid_pattern", 32'(vpat), 32'h3C);
        wait_drain();

        // Backpressure: five stalled cycles in the middle of a word.
        push_exp(tbl[4]);
        push_exp(tbl[5]);
        fork
            begin
                send(tbl[4].fmt, tbl[4].word, tbl[4].last);
                send(tbl[5].fmt, tbl[5].word, tbl[5].last);
            end
            begin
                wait_valid();
                @(posedge clk); #1;
                out_ready = 1'b0;
                held = '0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    if (c == 0) held = out_color;
                    else chk("stall_color_stable", out_color, held);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of a word drops the rest; next word starts at pixel 0.
        push_exp(tbl[4]);
        send(tbl[4].fmt, tbl[4].word, tbl[4].last);
        wait_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_color", out_color, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_after_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_after_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        run_vec(tbl[4]);
        wait_drain();

        // Clear in the middle of a word behaves the same way.
        push_exp(tbl[6]);
        send(tbl[6].fmt, tbl[6].word, tbl[6].last);
        wait_valid();
        @(posedge clk); #1;
        clear = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("clear_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        @(posedge clk); #1;
        clear = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("clear_out_valid", 32'(out_valid), 32'd0);
        chk("clear_after_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        run_vec(tbl[6]);
        wait_drain();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
